rrf_entry_commit: RTL and testbench
===================================

// Module: rrf_entry_commit
// PURPOSE
//  Retire side of the rename-register-file (RRF) ring. Allocation hands out tags at rrfptr.
//  This block tracks per-entry allocated/finished state and retires up to 2 oldest finished entries per cycle, in order, from comptr.
//  Drives com_inst_num_o back to the allocator (freenum/rrf_allocatable) and emits ARF write-back requests.
//  No flush/branch recovery in this revision.
// PARAMETERS
//  RRF_NUM  64  ring depth; must be a power of two; taken from `RRF_NUM
//  RRF_SEL  6   log2(RRF_NUM); taken from `RRF_SEL
//  REG_SEL  5   architectural register index width
// PORTS
//  clk_i            in   1        clock; all state changes on posedge
//  reset_i          in   1        asynchronous, active-high reset
//  alloc_valid_i    in   1        DP allocated an entry this cycle (non-stalled dispatch)
//  alloc_rrftag_i   in   RRF_SEL  tag allocated (equals allocator rrfptr)
//  alloc_dst_val_i  in   1        instruction writes an architectural register
//  alloc_dst_arf_i  in   REG_SEL  architectural destination register index
//  done1_valid_i    in   1        execution completion port 1 valid
//  done1_rrftag_i   in   RRF_SEL  completing tag, port 1
//  done2_valid_i    in   1        execution completion port 2 valid
//  done2_rrftag_i   in   RRF_SEL  completing tag, port 2
//  com_inst_num_o   out  2        entries retired this cycle (0..2); combinational from registered state only
//  comptr_o         out  RRF_SEL  oldest unretired tag (registered)
//  arf_we1_o        out  1        retire slot 1 writes ARF
//  arf_waddr1_o     out  REG_SEL  ARF index, slot 1
//  arf_rrftag1_o    out  RRF_SEL  RRF tag to copy, slot 1 (= comptr_o)
//  arf_we2_o        out  1        retire slot 2 writes ARF
//  arf_waddr2_o     out  REG_SEL  ARF index, slot 2
//  arf_rrftag2_o    out  RRF_SEL  RRF tag, slot 2 (= comptr_o+1 mod RRF_NUM)
//  nextcomcyc_o     out  1        registered; 1 for one cycle after comptr wraps past RRF_NUM-1
// BEHAVIOUR
//  Reset (async): comptr_o=0, nextcomcyc_o=0, all valid[]/done[]/dstval[]=0 -> com_inst_num_o=0, arf_we*=0.
//  Per entry: valid, done, dstval, dstarf. Alloc: valid=1, done=0, dstval/dstarf captured.
//  Completion: done[tag]=1 at edge; ignored if valid[tag]=0. Both ports same tag = one set.
//  Slot1 retires iff valid[c]&done[c], c=comptr. Slot2 retires iff slot1 retires & valid[c+1]&done[c+1].
//  com_inst_num_o = slot1+slot2; never retires slot2 alone (strict program order).
//  arf_weN_o = slotN retires & dstval of that entry; addr/tag outputs valid only when arf_weN_o=1.
//  Latency: done at edge N -> visible to retire logic in cycle N+1 (no same-cycle bypass).
//  Edge after retire: clear valid/done of retired entries; comptr <= (comptr+com_inst_num) mod RRF_NUM.
//  nextcomcyc_o <= 1 iff the new comptr is numerically less than the old comptr (wrap), else 0.
//  Wrap: RRF_NUM-1 and 0 form a legal retire pair; index arithmetic truncates to RRF_SEL bits.
//  Alloc and retire same index same cycle (allocator reuses freed slot via freenum+com_inst_num): alloc wins; entry ends valid=1, done=0.
//  Completion and alloc same tag same cycle: illegal upstream; alloc wins.
//  Full ring (all valid): handled identically; no overflow state here (allocator owns freenum).
//  Empty (valid[comptr]=0): com_inst_num_o=0, comptr holds.
//  Reset asserted mid-operation: all entries dropped immediately; no partial retire.
// STRUCTURE
//  Shared package (Consts.v): `RRF_NUM, `RRF_SEL, `REG_SEL; no new typedefs.
//  Sub-module rrf_status_table: valid/done/dstval/dstarf arrays, 1 alloc port, 2 done ports,
//  2 clear ports, 2 read ports (c, c+1); alloc-over-clear priority lives there.
//  Top: retire select, comptr/nextcomcyc registers, ARF request outputs.
// TESTING
//  Reset then idle -> com_inst_num_o=0, comptr_o=0, arf_we1/2=0 for 10 cycles.
//  Alloc tags 0,1 (dst r3,r7), done 1 then 0 -> no retire until 0 done; next cycle com=2, waddr1=3, waddr2=7, comptr 0->2.
//  Alloc 0..2, done 0 and 2 only -> com=1 (tag0); tag2 held until tag1 done, then com=2.
//  Fill and retire across wrap: comptr=63, tags 63,0 done -> com=2, comptr=1, nextcomcyc_o=1 one cycle.
//  Alloc tag 5 same cycle tag 5 retires -> next cycle valid[5]=1, done[5]=0, no retire of 5.
//  Assert reset_i asynchronously with 4 finished entries -> outputs zero before next edge; no ARF write afterwards.

Source files
------------

// File: rtl/rrf_entry_commit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rrf_entry_commit_pkg
//  Description : Shared sizing constants for the rename-register-file retire
//                slice, plus a ring-index increment helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package rrf_entry_commit_pkg;

    localparam int RRF_NUM = 64;   // ring depth, power of two
    localparam int RRF_SEL = 6;    // log2(RRF_NUM)
    localparam int REG_SEL = 5;    // architectural register index width

    // Next ring index; the natural truncation to RRF_SEL bits gives the wrap.
    function automatic logic [RRF_SEL-1:0] rrf_inc(input logic [RRF_SEL-1:0] tag);
        return tag + {{(RRF_SEL-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rrf_entry_commit_if.sv
`default_nettype none
// ============================================================================
//  Module      : rrf_entry_commit_if
//  Description : Allocation, completion and retire/ARF write-back signals of
//                the RRF retire block.
//  Modports    : slave  - the retire block (consumes alloc/done, drives retire)
//                master - dispatch/execute/ARF side
//  Revision    : 1.0 - initial release
// ============================================================================
interface rrf_entry_commit_if;
    import rrf_entry_commit_pkg::*;

    logic               alloc_valid_i;
    logic [RRF_SEL-1:0] alloc_rrftag_i;
    logic               alloc_dst_val_i;
    logic [REG_SEL-1:0] alloc_dst_arf_i;
    logic               done1_valid_i;
    logic [RRF_SEL-1:0] done1_rrftag_i;
    logic               done2_valid_i;
    logic [RRF_SEL-1:0] done2_rrftag_i;
    logic [1:0]         com_inst_num_o;
    logic [RRF_SEL-1:0] comptr_o;
    logic               arf_we1_o;
    logic [REG_SEL-1:0] arf_waddr1_o;
    logic [RRF_SEL-1:0] arf_rrftag1_o;
    logic               arf_we2_o;
    logic [REG_SEL-1:0] arf_waddr2_o;
    logic [RRF_SEL-1:0] arf_rrftag2_o;
    logic               nextcomcyc_o;

    modport slave (
        input  alloc_valid_i, alloc_rrftag_i, alloc_dst_val_i, alloc_dst_arf_i,
        input  done1_valid_i, done1_rrftag_i, done2_valid_i, done2_rrftag_i,
        output com_inst_num_o, comptr_o,
        output arf_we1_o, arf_waddr1_o, arf_rrftag1_o,
        output arf_we2_o, arf_waddr2_o, arf_rrftag2_o,
        output nextcomcyc_o
    );

    modport master (
        output alloc_valid_i, alloc_rrftag_i, alloc_dst_val_i, alloc_dst_arf_i,
        output done1_valid_i, done1_rrftag_i, done2_valid_i, done2_rrftag_i,
        input  com_inst_num_o, comptr_o,
        input  arf_we1_o, arf_waddr1_o, arf_rrftag1_o,
        input  arf_we2_o, arf_waddr2_o, arf_rrftag2_o,
        input  nextcomcyc_o
    );

endinterface
`default_nettype wire

// File: rtl/rrf_entry_commit_status_table.sv
`default_nettype none
// ============================================================================
//  Module      : rrf_status_table
//  Description : Per-entry valid/done/dstval/dstarf state of the RRF ring.
//                One alloc port, two completion ports, two clear (retire)
//                ports and two read ports.
//  Ports       : clk_i, reset_i      - clock, async active-high reset
//                alloc_*             - entry allocation (wins over clear/done)
//                done1_*, done2_*    - completion marks (ignored if not valid)
//                clr1_*, clr2_*      - retire clears
//                rd1_*, rd2_*        - entry state at the two read tags
//  Revision    : 1.0 - initial release
// ============================================================================
module rrf_status_table
    import rrf_entry_commit_pkg::*;
(
    input  wire logic               clk_i,
    input  wire logic               reset_i,
    input  wire logic               alloc_en_i,
    input  wire logic [RRF_SEL-1:0] alloc_tag_i,
    input  wire logic               alloc_dstval_i,
    input  wire logic [REG_SEL-1:0] alloc_dstarf_i,
    input  wire logic               done1_en_i,
    input  wire logic [RRF_SEL-1:0] done1_tag_i,
    input  wire logic               done2_en_i,
    input  wire logic [RRF_SEL-1:0] done2_tag_i,
    input  wire logic               clr1_en_i,
    input  wire logic [RRF_SEL-1:0] clr1_tag_i,
    input  wire logic               clr2_en_i,
    input  wire logic [RRF_SEL-1:0] clr2_tag_i,
    input  wire logic [RRF_SEL-1:0] rd1_tag_i,
    input  wire logic [RRF_SEL-1:0] rd2_tag_i,
    output logic                    rd1_valid_o,
    output logic                    rd1_done_o,
    output logic                    rd1_dstval_o,
    output logic [REG_SEL-1:0]      rd1_dstarf_o,
    output logic                    rd2_valid_o,
    output logic                    rd2_done_o,
    output logic                    rd2_dstval_o,
    output logic [REG_SEL-1:0]      rd2_dstarf_o
);

    logic [RRF_NUM-1:0] r_valid;
    logic [RRF_NUM-1:0] r_done;
    logic [RRF_NUM-1:0] r_dstval;
    logic [REG_SEL-1:0] r_dstarf [RRF_NUM];

    logic [RRF_NUM-1:0] w_alloc_hit;
    logic [RRF_NUM-1:0] w_clr_hit;
    logic [RRF_NUM-1:0] w_done_hit;

    // One-hot decode of each port; two ports naming the same tag simply OR.
    always_comb begin
        w_alloc_hit = '0;
        w_clr_hit   = '0;
        w_done_hit  = '0;
        if (alloc_en_i) w_alloc_hit[alloc_tag_i] = 1'b1;
        if (clr1_en_i)  w_clr_hit[clr1_tag_i]    = 1'b1;
        if (clr2_en_i)  w_clr_hit[clr2_tag_i]    = 1'b1;
        if (done1_en_i) w_done_hit[done1_tag_i]  = 1'b1;
        if (done2_en_i) w_done_hit[done2_tag_i]  = 1'b1;
    end

    // Priority per entry: alloc > clear > done. The allocator may hand out a
    // slot in the same cycle it retires, so a fresh alloc must survive the clear.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_valid  <= '0;
            r_done   <= '0;
            r_dstval <= '0;
            for (int i = 0; i < RRF_NUM; i++) begin
                r_dstarf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RRF_NUM; i++) begin
                if (w_alloc_hit[i]) begin
                    r_valid[i]  <= 1'b1;
                    r_done[i]   <= 1'b0;
                    r_dstval[i] <= alloc_dstval_i;
                    r_dstarf[i] <= alloc_dstarf_i;
                end else if (w_clr_hit[i]) begin
                    r_valid[i] <= 1'b0;
                    r_done[i]  <= 1'b0;
                end else if (w_done_hit[i] && r_valid[i]) begin
                    r_done[i] <= 1'b1;
                end
            end
        end
    end

    assign rd1_valid_o  = r_valid[rd1_tag_i];
    assign rd1_done_o   = r_done[rd1_tag_i];
    assign rd1_dstval_o = r_dstval[rd1_tag_i];
    assign rd1_dstarf_o = r_dstarf[rd1_tag_i];
    assign rd2_valid_o  = r_valid[rd2_tag_i];
    assign rd2_done_o   = r_done[rd2_tag_i];
    assign rd2_dstval_o = r_dstval[rd2_tag_i];
    assign rd2_dstarf_o = r_dstarf[rd2_tag_i];

endmodule
`default_nettype wire

// File: rtl/rrf_entry_commit.sv
`default_nettype none
// ============================================================================
//  Module      : rrf_entry_commit
//  Description : Retire side of the RRF ring. Retires up to two oldest
//                finished entries per cycle in program order from comptr,
//                reports the count back to the allocator and issues ARF
//                write-back requests.
//  Ports       : clk_i        - clock
//                reset_i      - asynchronous active-high reset
//                bus (slave)  - alloc/done inputs; com_inst_num_o, comptr_o,
//                               arf_we/waddr/rrftag 1..2, nextcomcyc_o outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module rrf_entry_commit
    import rrf_entry_commit_pkg::*;
(
    input  wire logic          clk_i,
    input  wire logic          reset_i,
    rrf_entry_commit_if.slave  bus
);

    logic [RRF_SEL-1:0] r_comptr;
    logic               r_nextcomcyc;

    logic [RRF_SEL-1:0] w_tag0;
    logic [RRF_SEL-1:0] w_tag1;
    logic               w_valid0, w_done0, w_dstval0;
    logic               w_valid1, w_done1, w_dstval1;
    logic [REG_SEL-1:0] w_dstarf0, w_dstarf1;
    logic               w_ret1, w_ret2;
    logic [1:0]         w_com_num;
    logic [RRF_SEL-1:0] w_comptr_nxt;

    assign w_tag0 = r_comptr;
    assign w_tag1 = rrf_inc(r_comptr);

    rrf_status_table u_table (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .alloc_en_i     (bus.alloc_valid_i),
        .alloc_tag_i    (bus.alloc_rrftag_i),
        .alloc_dstval_i (bus.alloc_dst_val_i),
        .alloc_dstarf_i (bus.alloc_dst_arf_i),
        .done1_en_i     (bus.done1_valid_i),
        .done1_tag_i    (bus.done1_rrftag_i),
        .done2_en_i     (bus.done2_valid_i),
        .done2_tag_i    (bus.done2_rrftag_i),
        .clr1_en_i      (w_ret1),
        .clr1_tag_i     (w_tag0),
        .clr2_en_i      (w_ret2),
        .clr2_tag_i     (w_tag1),
        .rd1_tag_i      (w_tag0),
        .rd2_tag_i      (w_tag1),
        .rd1_valid_o    (w_valid0),
        .rd1_done_o     (w_done0),
        .rd1_dstval_o   (w_dstval0),
        .rd1_dstarf_o   (w_dstarf0),
        .rd2_valid_o    (w_valid1),
        .rd2_done_o     (w_done1),
        .rd2_dstval_o   (w_dstval1),
        .rd2_dstarf_o   (w_dstarf1)
    );

    // Slot 2 is gated by slot 1 so an entry never retires ahead of an older one.
    assign w_ret1    = w_valid0 & w_done0;
    assign w_ret2    = w_ret1 & w_valid1 & w_done1;
    assign w_com_num = {w_ret2, w_ret1 & ~w_ret2};

    assign w_comptr_nxt = r_comptr + {{(RRF_SEL-2){1'b0}}, w_com_num};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_comptr     <= '0;
            r_nextcomcyc <= 1'b0;
        end else begin
            r_comptr     <= w_comptr_nxt;
            // A smaller new pointer means the ring wrapped through RRF_NUM-1.
            r_nextcomcyc <= (w_comptr_nxt < r_comptr);
        end
    end

    assign bus.com_inst_num_o = w_com_num;
    assign bus.comptr_o       = r_comptr;
    assign bus.nextcomcyc_o   = r_nextcomcyc;
    assign bus.arf_we1_o      = w_ret1 & w_dstval0;
    assign bus.arf_waddr1_o   = w_dstarf0;
    assign bus.arf_rrftag1_o  = w_tag0;
    assign bus.arf_we2_o      = w_ret2 & w_dstval1;
    assign bus.arf_waddr2_o   = w_dstarf1;
    assign bus.arf_rrftag2_o  = w_tag1;

endmodule
`default_nettype wire

// File: tb/tb_rrf_entry_commit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rrf_entry_commit
//  Description : Directed self-checking bench for rrf_entry_commit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rrf_entry_commit;
    import rrf_entry_commit_pkg::*;

    logic clk_i = 1'b0;
    logic reset_i;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [RRF_SEL-1:0] m_comptr;

    rrf_entry_commit_if bus();

    rrf_entry_commit dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        bus.alloc_valid_i   = 1'b0;
        bus.alloc_rrftag_i  = '0;
        bus.alloc_dst_val_i = 1'b0;
        bus.alloc_dst_arf_i = '0;
        bus.done1_valid_i   = 1'b0;
        bus.done1_rrftag_i  = '0;
        bus.done2_valid_i   = 1'b0;
        bus.done2_rrftag_i  = '0;
    endtask

    task automatic alloc(input logic [RRF_SEL-1:0] tag, input logic dv, input logic [REG_SEL-1:0] arf);
        bus.alloc_valid_i   = 1'b1;
        bus.alloc_rrftag_i  = tag;
        bus.alloc_dst_val_i = dv;
        bus.alloc_dst_arf_i = arf;
        step();
        bus.alloc_valid_i   = 1'b0;
    endtask

    task automatic set_done(input logic v1, input logic [RRF_SEL-1:0] t1,
                            input logic v2, input logic [RRF_SEL-1:0] t2);
        bus.done1_valid_i  = v1;
        bus.done1_rrftag_i = t1;
        bus.done2_valid_i  = v2;
        bus.done2_rrftag_i = t2;
    endtask

    // Single-entry alloc/complete/retire until the pointer reaches target.
    task automatic advance(input logic [RRF_SEL-1:0] target);
        for (int k = 0; k < 70 && m_comptr != target; k++) begin
            alloc(m_comptr, 1'b0, 5'd0);
            set_done(1'b1, m_comptr, 1'b0, 6'd0);
            step();
            set_done(1'b0, 6'd0, 1'b0, 6'd0);
            n_tests++;
            if (bus.com_inst_num_o !== 2'd1) begin
                $display("FAIL advance_com tag %0d: got %0d required 1", m_comptr, bus.com_inst_num_o); n_fail++;
            end
            step();
            m_comptr = m_comptr + 6'd1;
        end
        n_tests++;
        if (bus.comptr_o !== target) begin
            $display("FAIL advance_comptr: got %0d required %0d", bus.comptr_o, target); n_fail++;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_i = 1'b1;
        step(); step();
        reset_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_tests++;
            if (bus.com_inst_num_o !== 2'd0 || bus.comptr_o !== 6'd0 ||
                bus.arf_we1_o !== 1'b0 || bus.arf_we2_o !== 1'b0 || bus.nextcomcyc_o !== 1'b0) begin
                $display("FAIL reset_idle cyc %0d: got com=%0d ptr=%0d we1=%b we2=%b ncc=%b required 0", i,
                         bus.com_inst_num_o, bus.comptr_o, bus.arf_we1_o, bus.arf_we2_o, bus.nextcomcyc_o);
                n_fail++;
            end
        end
        m_comptr = 6'd0;
    endtask

    task automatic test_inorder_pair();
        alloc(6'd0, 1'b1, 5'd3);
        alloc(6'd1, 1'b1, 5'd7);
        set_done(1'b1, 6'd1, 1'b0, 6'd0);
        step();
        set_done(1'b0, 6'd0, 1'b0, 6'd0);
        n_tests++;
        if (bus.com_inst_num_o !== 2'd0 || bus.arf_we1_o !== 1'b0 || bus.arf_we2_o !== 1'b0) begin
            $display("FAIL pair_no_early: got com=%0d we1=%b we2=%b required 0", bus.com_inst_num_o, bus.arf_we1_o, bus.arf_we2_o); n_fail++;
        end
        set_done(1'b1, 6'd0, 1'b0, 6'd0);
        step();
        set_done(1'b0, 6'd0, 1'b0, 6'd0);
        n_tests++;
        if (bus.com_inst_num_o !== 2'd2) begin
            $display("FAIL pair_com: got %0d required 2", bus.com_inst_num_o); n_fail++;
        end
        n_tests++;
        if (bus.arf_we1_o !== 1'b1 || bus.arf_waddr1_o !== 5'd3 || bus.arf_rrftag1_o !== 6'd0) begin
            $display("FAIL pair_slot1: got we=%b addr=%0d tag=%0d required 1/3/0", bus.arf_we1_o, bus.arf_waddr1_o, bus.arf_rrftag1_o); n_fail++;
        end
        n_tests++;
        if (bus.arf_we2_o !== 1'b1 || bus.arf_waddr2_o !== 5'd7 || bus.arf_rrftag2_o !== 6'd1) begin
            $display("FAIL pair_slot2: got we=%b addr=%0d tag=%0d required 1/7/1", bus.arf_we2_o, bus.arf_waddr2_o, bus.arf_rrftag2_o); n_fail++;
        end
        step();
        n_tests++;
        if (bus.comptr_o !== 6'd2 || bus.com_inst_num_o !== 2'd0 || bus.nextcomcyc_o !== 1'b0) begin
            $display("FAIL pair_after: got ptr=%0d com=%0d ncc=%b required 2/0/0", bus.comptr_o, bus.com_inst_num_o, bus.nextcomcyc_o); n_fail++;
        end
        m_comptr = 6'd2;
    endtask

    task automatic test_partial();
        alloc(6'd2, 1'b1, 5'd10);
        alloc(6'd3, 1'b0, 5'd11);
        alloc(6'd4, 1'b1, 5'd12);
        set_done(1'b1, 6'd2, 1'b1, 6'd4);
        step();
        set_done(1'b0, 6'd0, 1'b0, 6'd0);
        n_tests++;
        if (bus.com_inst_num_o !== 2'd1 || bus.arf_we1_o !== 1'b1 || bus.arf_waddr1_o !== 5'd10 || bus.arf_we2_o !== 1'b0) begin
            $display("FAIL partial_one: got com=%0d we1=%b a1=%0d we2=%b required 1/1/10/0",
                     bus.com_inst_num_o, bus.arf_we1_o, bus.arf_waddr1_o, bus.arf_we2_o); n_fail++;
        end
        step();
        n_tests++;
        if (bus.comptr_o !== 6'd3 || bus.com_inst_num_o !== 2'd0) begin
            $display("FAIL partial_hold: got ptr=%0d com=%0d required 3/0", bus.comptr_o, bus.com_inst_num_o); n_fail++;
        end
        // Both completion ports naming the same tag.
        set_done(1'b1, 6'd3, 1'b1, 6'd3);
        step();
        set_done(1'b0, 6'd0, 1'b0, 6'd0);
        n_tests++;
        if (bus.com_inst_num_o !== 2'd2 || bus.arf_we1_o !== 1'b0 || bus.arf_we2_o !== 1'b1 ||
            bus.arf_waddr2_o !== 5'd12 || bus.arf_rrftag2_o !== 6'd4) begin
            $display("FAIL partial_two: got com=%0d we1=%b we2=%b a2=%0d t2=%0d required 2/0/1/12/4",
                     bus.com_inst_num_o, bus.arf_we1_o, bus.arf_we2_o, bus.arf_waddr2_o, bus.arf_rrftag2_o); n_fail++;
        end
        step();
        n_tests++;
        if (bus.comptr_o !== 6'd5) begin
            $display("FAIL partial_ptr: got %0d required 5", bus.comptr_o); n_fail++;
        end
        m_comptr = 6'd5;
    endtask

    task automatic test_done_invalid();
        set_done(1'b1, 6'd5, 1'b0, 6'd0);
        step();
        set_done(1'b0, 6'd0, 1'b0, 6'd0);
        n_tests++;
        if (bus.com_inst_num_o !== 2'd0) begin
            $display("FAIL invalid_done_now: got %0d required 0", bus.com_inst_num_o); n_fail++;
        end
        alloc(6'd5, 1'b1, 5'd20);
        n_tests++;
        if (bus.com_inst_num_o !== 2'd0) begin
            $display("FAIL invalid_done_dropped: got %0d required 0", bus.com_inst_num_o); n_fail++;
        end
        set_done(1'b0, 6'd0, 1'b1, 6'd5);
        step();
        set_done(1'b0, 6'd0, 1'b0, 6'd0);
        n_tests++;
        if (bus.com_inst_num_o !== 2'd1 || bus.arf_waddr1_o !== 5'd20) begin
            $display("FAIL port2_done: got com=%0d a1=%0d required 1/20", bus.com_inst_num_o, bus.arf_waddr1_o); n_fail++;
        end
        step();
        m_comptr = 6'd6;
    endtask

    task automatic test_alloc_retire_same();
        alloc(6'd6, 1'b1, 5'd21);
        set_done(1'b1, 6'd6, 1'b0, 6'd0);
        step();
        set_done(1'b0, 6'd0, 1'b0, 6'd0);
        n_tests++;
        if (bus.com_inst_num_o !== 2'd1) begin
            $display("FAIL same_retire: got %0d required 1", bus.com_inst_num_o); n_fail++;
        end
        // Re-allocate tag 6 in the cycle it retires.
        alloc(6'd6, 1'b1, 5'd22);
        n_tests++;
        if (bus.comptr_o !== 6'd7 || bus.com_inst_num_o !== 2'd0) begin
            $display("FAIL same_after: got ptr=%0d com=%0d required 7/0", bus.comptr_o, bus.com_inst_num_o); n_fail++;
        end
        m_comptr = 6'd7;
    endtask

    task automatic test_wrap();
        advance(6'd63);
        alloc(6'd63, 1'b1, 5'd1);
        alloc(6'd0, 1'b1, 5'd2);
        set_done(1'b1, 6'd63, 1'b1, 6'd0);
        step();
        set_done(1'b0, 6'd0, 1'b0, 6'd0);
        n_tests++;
        if (bus.com_inst_num_o !== 2'd2 || bus.arf_rrftag1_o !== 6'd63 || bus.arf_rrftag2_o !== 6'd0 ||
            bus.arf_waddr1_o !== 5'd1 || bus.arf_waddr2_o !== 5'd2 || bus.nextcomcyc_o !== 1'b0) begin
            $display("FAIL wrap_retire: got com=%0d t1=%0d t2=%0d a1=%0d a2=%0d ncc=%b required 2/63/0/1/2/0",
                     bus.com_inst_num_o, bus.arf_rrftag1_o, bus.arf_rrftag2_o, bus.arf_waddr1_o, bus.arf_waddr2_o, bus.nextcomcyc_o); n_fail++;
        end
        step();
        n_tests++;
        if (bus.comptr_o !== 6'd1 || bus.nextcomcyc_o !== 1'b1) begin
            $display("FAIL wrap_ptr: got ptr=%0d ncc=%b required 1/1", bus.comptr_o, bus.nextcomcyc_o); n_fail++;
        end
        step();
        n_tests++;
        if (bus.comptr_o !== 6'd1 || bus.nextcomcyc_o !== 1'b0) begin
            $display("FAIL wrap_pulse: got ptr=%0d ncc=%b required 1/0", bus.comptr_o, bus.nextcomcyc_o); n_fail++;
        end
        m_comptr = 6'd1;
    endtask

    task automatic test_alloc_wins_seen();
        advance(6'd6);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (bus.com_inst_num_o !== 2'd0) begin
                $display("FAIL realloc_not_done cyc %0d: got %0d required 0", i, bus.com_inst_num_o); n_fail++;
            end
            step();
        end
        set_done(1'b1, 6'd6, 1'b0, 6'd0);
        step();
        set_done(1'b0, 6'd0, 1'b0, 6'd0);
        n_tests++;
        if (bus.com_inst_num_o !== 2'd1 || bus.arf_we1_o !== 1'b1 || bus.arf_waddr1_o !== 5'd22) begin
            $display("FAIL realloc_retire: got com=%0d we1=%b a1=%0d required 1/1/22",
                     bus.com_inst_num_o, bus.arf_we1_o, bus.arf_waddr1_o); n_fail++;
        end
        step();
        n_tests++;
        if (bus.comptr_o !== 6'd7) begin
            $display("FAIL realloc_ptr: got %0d required 7", bus.comptr_o); n_fail++;
        end
        m_comptr = 6'd7;
    endtask

    task automatic test_async_reset();
        alloc(6'd7, 1'b1, 5'd1);
        alloc(6'd8, 1'b1, 5'd2);
        alloc(6'd9, 1'b1, 5'd3);
        alloc(6'd10, 1'b1, 5'd4);
        set_done(1'b1, 6'd9, 1'b1, 6'd10);
        step();
        set_done(1'b1, 6'd7, 1'b1, 6'd8);
        step();
        set_done(1'b0, 6'd0, 1'b0, 6'd0);
        n_tests++;
        if (bus.com_inst_num_o !== 2'd2) begin
            $display("FAIL prereset_com: got %0d required 2", bus.com_inst_num_o); n_fail++;
        end
        #2;
        reset_i = 1'b1;
        #1;
        n_tests++;
        if (bus.com_inst_num_o !== 2'd0 || bus.arf_we1_o !== 1'b0 || bus.arf_we2_o !== 1'b0 ||
            bus.comptr_o !== 6'd0 || bus.nextcomcyc_o !== 1'b0) begin
            $display("FAIL async_reset: got com=%0d we1=%b we2=%b ptr=%0d ncc=%b required 0",
                     bus.com_inst_num_o, bus.arf_we1_o, bus.arf_we2_o, bus.comptr_o, bus.nextcomcyc_o); n_fail++;
        end
        step();
        reset_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (bus.com_inst_num_o !== 2'd0 || bus.arf_we1_o !== 1'b0 || bus.arf_we2_o !== 1'b0 || bus.comptr_o !== 6'd0) begin
                $display("FAIL post_reset cyc %0d: got com=%0d we1=%b we2=%b ptr=%0d required 0",
                         i, bus.com_inst_num_o, bus.arf_we1_o, bus.arf_we2_o, bus.comptr_o); n_fail++;
            end
        end
    endtask

    initial begin
        reset_i = 1'b1;
        clear_inputs();
        test_reset();
        test_inorder_pair();
        test_partial();
        test_done_invalid();
        test_alloc_retire_same();
        test_wrap();
        test_alloc_wins_seen();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
